// File: rtl/nv_nvdla_csb_req_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// nv_nvdla_csb_req_pipe
//
// Retiming and flow-control stage between the APB-to-CSB bridge (upstream)
// and the NVDLA core CSB slave (downstream).
//   - Requests pass through a 2-entry skid buffer with a registered ready.
//   - Reads and non-posted writes are counted as outstanding and gated by
//     MAX_OUTS; posted writes are never held back by that limit.
//   - Read data and write completions are registered on the way back.
//   - A watchdog answers a stuck transaction with an error response so the
//     bridge never waits forever.
//
// Ports
//   pclk, prst                      clock, async active-high reset
//   us_req_*                        request from the bridge (valid/ready)
//   us_rsp_valid/data/err           read data (or timeout error) pulse
//   us_wr_complete                  non-posted write completion pulse
//   ds_req_*                        request to the core (valid/ready)
//   ds_rsp_valid/data               read data from the core
//   ds_wr_complete                  write completion from the core
//   outs_cnt                        current outstanding count
//   timeout_evt                     one-cycle pulse on each watchdog fire
// ---------------------------------------------------------------------------
module nv_nvdla_csb_req_pipe #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter int                MAX_OUTS = 4,
    parameter int                TIMEOUT  = 1023,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_CAFE
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              us_req_valid,
    output logic              us_req_ready,
    input  logic [ADDR_W-1:0] us_req_addr,
    input  logic [DATA_W-1:0] us_req_wdat,
    input  logic              us_req_write,
    input  logic              us_req_nposted,
    output logic              us_rsp_valid,
    output logic [DATA_W-1:0] us_rsp_data,
    output logic              us_rsp_err,
    output logic              us_wr_complete,
    output logic              ds_req_valid,
    input  logic              ds_req_ready,
    output logic [ADDR_W-1:0] ds_req_addr,
    output logic [DATA_W-1:0] ds_req_wdat,
    output logic              ds_req_write,
    output logic              ds_req_nposted,
    input  logic              ds_rsp_valid,
    input  logic [DATA_W-1:0] ds_rsp_data,
    input  logic              ds_wr_complete,
    output logic [3:0]        outs_cnt,
    output logic              timeout_evt
);

    localparam int              ENT_W   = ADDR_W + DATA_W + 2;
    localparam int              TMR_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              WDOG_EN = (TIMEOUT != 0);
    localparam logic [3:0]      MAX_CNT = 4'(MAX_OUTS);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    // Buffer entry layout: {addr, wdat, write, nposted}
    logic [ENT_W-1:0] entry_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_nxt;
    logic             ready_q;

    logic [ENT_W-1:0] head;
    logic             head_rsp;
    logic             push;
    logic             pop;

    logic [3:0]       outs_q;
    logic [3:0]       outs_nxt;
    logic [4:0]       outs_sum;
    logic [4:0]       outs_dec;
    logic [TMR_W-1:0] timer_q;
    logic             any_rsp;
    logic             fire;

    assign head           = entry_q[rd_ptr_q];
    assign ds_req_addr    = head[ENT_W-1 -: ADDR_W];
    assign ds_req_wdat    = head[DATA_W+1:2];
    assign ds_req_write   = head[1];
    assign ds_req_nposted = head[0];

    // A read or a non-posted write will come back with a response
    assign head_rsp = ~head[1] | head[0];

    // Posted writes bypass the outstanding limit; anything else at the
    // head blocks the whole queue until the count drops.
    assign ds_req_valid = (count_q != 2'd0) & (~head_rsp | (outs_q < MAX_CNT));

    assign push         = us_req_valid & ready_q;
    assign pop          = ds_req_valid & ds_req_ready;
    assign us_req_ready = ready_q;
    assign outs_cnt     = outs_q;

    // Occupancy after this cycle's push/pop; ready is derived from it so
    // the bridge sees a registered ready that never over-commits.
    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + 2'd1;
            2'b01:   count_nxt = count_q - 2'd1;
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            ready_q    <= 1'b0;
        end else begin
            if (push) begin
                entry_q[wr_ptr_q] <= {us_req_addr, us_req_wdat, us_req_write, us_req_nposted};
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_nxt;
            ready_q <= (count_nxt < 2'd2);
        end
    end

    // The watchdog only fires when nothing real arrives in the same cycle,
    // so a genuine response always wins over a timeout.
    assign any_rsp = ds_rsp_valid | ds_wr_complete;
    assign fire    = WDOG_EN && (outs_q != 4'd0) && (timer_q == TMR_MAX) && !any_rsp;

    // Up to one increment and two decrements per cycle; the result
    // saturates at zero so a late response after a timeout is harmless.
    always_comb begin
        outs_sum = {1'b0, outs_q} + {4'd0, pop & head_rsp};
        outs_dec = {4'd0, ds_rsp_valid} + {4'd0, ds_wr_complete} + {4'd0, fire};
        outs_nxt = (outs_sum > outs_dec) ? 4'(outs_sum - outs_dec) : 4'd0;
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            outs_q  <= 4'd0;
            timer_q <= '0;
        end else begin
            outs_q <= outs_nxt;
            if (!WDOG_EN || outs_q == 4'd0 || any_rsp || fire) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TMR_W'(1);
            end
        end
    end

    // Upstream responses are registered with no backpressure; the data
    // register only loads when there is something to return.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            us_rsp_valid   <= 1'b0;
            us_rsp_data    <= '0;
            us_rsp_err     <= 1'b0;
            us_wr_complete <= 1'b0;
            timeout_evt    <= 1'b0;
        end else begin
            us_rsp_valid   <= ds_rsp_valid | fire;
            us_rsp_err     <= fire;
            us_wr_complete <= ds_wr_complete;
            timeout_evt    <= fire;
            if (ds_rsp_valid) begin
                us_rsp_data <= ds_rsp_data;
            end else if (fire) begin
                us_rsp_data <= ERR_DATA;
            end
        end
    end

endmodule
